imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode stage.
- Widens an IN_W-bit instruction immediate to OUT_W bits. Four modes are selectable per transfer: sign, zero, shifted branch offset, and upper-immediate.
- Registered output with a valid/ready handshake and a 2-entry skid buffer, so decode can stall without losing an immediate.

Parameters:
- IN_W, 16, immediate input width; legal range 1..OUT_W.
- OUT_W, 32, extended output width; must be ≥ IN_W.
- SHIFT, 2, left-shift amount for mode 2; legal range 0..OUT_W-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents an immediate.
- in_ready  out  1  block can accept an immediate this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extension mode, sampled with in_imm.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  OUT_W  extended immediate.
- out_mode  out  2  mode that produced out_data, for debug and trace.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle):
  - out_valid=0, out_data=0, out_mode=0.
  - Skid entry cleared (skid_valid=0).
  - in_ready=1 immediately after reset is applied.
  - Reset mid-transfer discards any buffered data; nothing is replayed after release.
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer occurs when out_valid & out_ready at a rising edge.
- Extension function, combinational on the accepted input (x = in_imm, s = x[IN_W-1]):
  - Mode 0, sign extend: {(OUT_W-IN_W) copies of s, x}.
  - Mode 1, zero extend: {(OUT_W-IN_W) zeros, x}.
  - Mode 2, branch offset: sign-extend x to OUT_W first, then shift left by SHIFT. Zeros fill the LSBs; bits shifted past bit OUT_W-1 are dropped with no error flag.
  - Mode 3, upper immediate: {x, (OUT_W-IN_W) zeros}.
  - When IN_W==OUT_W, modes 0, 1 and 3 all return x unchanged.
- Pipeline: output register plus one skid register.
  - Latency is exactly 1 cycle: an immediate accepted at edge N has out_valid=1 after edge N whenever the output register is empty or drained at edge N.
  - in_ready = ~skid_valid. It is a register output with no combinational path from out_ready.
- Output register empty, or drained this edge:
  - Incoming result loads the output register.
  - If the skid is occupied, the skid content loads the output register first, and the incoming result goes to the skid.
- Output register full and not drained:
  - Incoming result is written to the skid; in_ready falls on the next cycle.
- Ordering: results leave strictly in acceptance order. No drops and no duplicates.
- Stability: while out_valid=1 and out_ready=0, out_data and out_mode are held stable.
- Both registers full: in_ready=0, and in_imm/in_mode are ignored even if in_valid=1.
- Simultaneous accept and drain with the skid full: the skid moves to output, the new item goes to the skid, and in_ready stays 0. This case cannot occur while in_ready=0, so it is a no-op guard only.
- in_mode is captured per transfer. Changing it while in_valid is high but not accepted has no effect until acceptance.
- No X propagation: out_data is never updated while no transfer occurs.

Test Plan (IN_W=16, OUT_W=32, SHIFT=2):
- Mode sweep with out_ready=1:
  - Mode 0, 0x8001 → 0xFFFF8001.
  - Mode 1, 0x8001 → 0x00008001.
  - Mode 2, 0xFFFF → 0xFFFFFFFC.
  - Mode 2, 0x0010 → 0x00000040.
  - Mode 3, 0x1234 → 0x12340000.
  - Each result appears exactly 1 cycle after acceptance, with out_mode matching.
- Backpressure:
  - With out_ready=0, push A=0x0001 (mode 0) then B=0x7FFF (mode 1) → in_ready=0 after B; a third push C=0x0002 is held by upstream.
  - Raise out_ready → out_data shows 0x00000001, then 0x00007FFF, then C=0x00000002 on consecutive cycles; C is accepted once in_ready returns to 1.
- Streaming: 100 back-to-back random immediates/modes with out_ready=1 → one result per cycle, in_ready constantly 1, every result matches the reference model.
- Random stalls: random in_valid/out_ready at 50% each over 1000 transfers → scoreboard shows in-order, lossless, duplicate-free output, and out_data stable during stall cycles.
- Reset mid-operation: fill both registers, then assert rst_n=0 between clock edges → out_valid=0, out_data=0 and in_ready=1 asynchronously. After release, the first result out is the first item pushed after reset.
- Parameter corner, IN_W=OUT_W=32 and SHIFT=0:
  - Mode 0, 1 or 3 on 0x80000000 → 0x80000000.
  - Mode 2 on 0x80000000 → 0x80000000.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit: widens IN_W-bit immediates to OUT_W bits
// in one of four modes, behind a registered valid/ready output with a skid entry.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  logic signed [IN_W-1:0] imm_s;
  logic [OUT_W-1:0]       sext;
  logic [OUT_W-1:0]       zext;
  logic [OUT_W-1:0]       ext_data;

  logic                   skid_valid;
  logic [OUT_W-1:0]       skid_data;
  logic [1:0]             skid_mode;

  logic                   accept;
  logic                   out_free;

  assign imm_s = in_imm;

  // Width casts keep the IN_W == OUT_W case free of zero-width replications.
  always_comb begin
    sext = OUT_W'(imm_s);
    zext = OUT_W'(in_imm);
    ext_data = sext;
    case (in_mode)
      2'd0: ext_data = sext;
      2'd1: ext_data = zext;
      2'd2: ext_data = sext << SHIFT;
      2'd3: ext_data = zext << (OUT_W - IN_W);
      default: ext_data = sext;
    endcase
  end

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= 2'd0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_mode  <= 2'd0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Older skid entry goes out first to preserve acceptance order.
        out_valid <= 1'b1;
        out_data  <= skid_data;
        out_mode  <= skid_mode;
        if (accept) begin
          skid_data <= ext_data;
          skid_mode <= in_mode;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= ext_data;
        out_mode  <= in_mode;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_mode  <= in_mode;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode sweep, backpressure,
// random streaming/stalls against a queue model, mid-operation reset, wide corner.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_imm;
  logic [1:0]  w_in_mode;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_data;
  logic [1:0]  w_out_mode;

  int errors = 0;
  int checks = 0;
  logic [33:0] sb_q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  imm_extend_pipe #(.IN_W(32), .OUT_W(32), .SHIFT(0)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_imm(w_in_imm), .in_mode(w_in_mode),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_mode(w_out_mode)
  );

  // Reference: plain integer arithmetic on the immediate value.
  function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] m);
    longint v;
    longint r;
    v = longint'(x);
    if (x >= 16'h8000) v = v - 65536;
    case (m)
      2'd0: r = v;
      2'd1: r = longint'(x);
      2'd2: r = v * 4;
      default: r = longint'(x) * 65536;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs set; advances one cycle, scoring transfers.
  task automatic tick(input string tag);
    logic        acc;
    logic        drn;
    logic        held;
    logic [33:0] hold_val;
    logic [33:0] exp;
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    held = out_valid & ~out_ready;
    hold_val = {out_mode, out_data};
    if (drn) begin
      if (sb_q.size() == 0) chk({tag, "_spurious"}, 64'(1), 64'(0));
      else begin
        exp = sb_q.pop_front();
        chk({tag, "_order"}, 64'({out_mode, out_data}), 64'(exp));
      end
    end
    if (acc) sb_q.push_back({in_mode, ref_ext(in_imm, in_mode)});
    @(posedge clk);
    #1;
    if (held) begin
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_hold_data"}, 64'({out_mode, out_data}), 64'(hold_val));
    end
    @(negedge clk);
  endtask

  typedef struct { logic [15:0] imm; logic [1:0] mode; logic [31:0] exp; } vec_t;
  vec_t sweep[5];

  initial begin
    int accepted;
    int cycles;
    sweep[0] = '{16'h8001, 2'd0, 32'hFFFF8001};
    sweep[1] = '{16'h8001, 2'd1, 32'h00008001};
    sweep[2] = '{16'hFFFF, 2'd2, 32'hFFFFFFFC};
    sweep[3] = '{16'h0010, 2'd2, 32'h00000040};
    sweep[4] = '{16'h1234, 2'd3, 32'h12340000};

    rst_n = 1'b0;
    in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_imm = '0; w_in_mode = '0; w_out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_mode", 64'(out_mode), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode sweep: result visible one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_imm = sweep[i].imm; in_mode = sweep[i].mode;
      tick("sweep");
      chk($sformatf("sweep%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("sweep%0d_data", i), 64'(out_data), 64'(sweep[i].exp));
      chk($sformatf("sweep%0d_mode", i), 64'(out_mode), 64'(sweep[i].mode));
    end
    in_valid = 1'b0;
    tick("sweep_drain");
    chk("sweep_empty", 64'(out_valid), 64'(0));

    // Backpressure: fill output and skid, C held until in_ready returns.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'd0; tick("bp");
    chk("bp_ready_after_a", 64'(in_ready), 64'(1));
    in_imm = 16'h7FFF; in_mode = 2'd1; tick("bp");
    chk("bp_ready_after_b", 64'(in_ready), 64'(0));
    in_imm = 16'h0002; in_mode = 2'd0; tick("bp");
    chk("bp_ready_stall", 64'(in_ready), 64'(0));
    chk("bp_hold_a", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    chk("bp_out_a", 64'(out_data), 64'h1);
    tick("bp");
    chk("bp_out_b", 64'(out_data), 64'h7FFF);
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    tick("bp");
    in_valid = 1'b0;
    chk("bp_out_c", 64'(out_data), 64'h2);
    chk("bp_out_c_valid", 64'(out_valid), 64'(1));
    tick("bp");
    chk("bp_queue_empty", 64'(sb_q.size()), 64'(0));

    // Streaming: back-to-back, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_imm = 16'($urandom);
      in_mode = 2'($urandom_range(0, 3));
      chk("stream_in_ready", 64'(in_ready), 64'(1));
      tick("stream");
      chk("stream_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    tick("stream");
    chk("stream_queue_empty", 64'(sb_q.size()), 64'(0));

    // Random stalls on both sides.
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_imm = 16'($urandom);
      in_mode = 2'($urandom_range(0, 3));
      if (in_valid && in_ready) accepted++;
      tick("rand");
      cycles++;
    end
    chk("rand_accepted", 64'(accepted), 64'(1000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    while ((out_valid || sb_q.size() != 0) && cycles < 10) begin
      tick("rand_drain");
      cycles++;
    end
    chk("rand_queue_empty", 64'(sb_q.size()), 64'(0));
    chk("rand_out_idle", 64'(out_valid), 64'(0));

    // Reset between edges with both registers full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1111; in_mode = 2'd1; tick("rst");
    in_imm = 16'h2222; tick("rst");
    in_valid = 1'b0;
    chk("rst_full", 64'(in_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_data", 64'(out_data), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h8000; in_mode = 2'd0;
    tick("post_rst");
    in_valid = 1'b0;
    chk("post_rst_first", 64'(out_data), 64'hFFFF8000);
    tick("post_rst");
    chk("post_rst_idle", 64'(out_valid), 64'(0));

    // IN_W == OUT_W, SHIFT == 0 corner.
    for (int m = 0; m < 4; m++) begin
      w_in_valid = 1'b1; w_in_imm = 32'h80000000; w_in_mode = 2'(m);
      @(posedge clk);
      #1;
      chk($sformatf("wide_mode%0d_data", m), 64'(w_out_data), 64'h80000000);
      chk($sformatf("wide_mode%0d_valid", m), 64'(w_out_valid), 64'(1));
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
